// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator: turns a write/read command stream into single AXI4-Lite
// transactions and returns each result on a response stream.
// Ports: cmd_* (command in, valid/ready), rsp_* (response out, valid/ready),
//        M_AXI_* (AXI4-Lite master), busy, txn_cntr / err_cntr (debug counters).
module axi_lite_cmd_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 30,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic                            rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY,
    output logic                            busy,
    output logic [31:0]                     txn_cntr,
    output logic [31:0]                     err_cntr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_RESP,
        S_RD_REQ,
        S_RD_DATA,
        S_RSP
    } state_e;

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int SW = C_M_AXI_DATA_WIDTH / 8;

    state_e          state_q, state_d;
    logic            write_q, write_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   wstrb_q, wstrb_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [1:0]      resp_q, resp_d;
    logic [31:0]     txn_q, txn_d;
    logic [31:0]     err_q, err_d;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q   <= S_IDLE;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= 2'b00;
            txn_q     <= 32'd0;
            err_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            txn_q     <= txn_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        txn_d     = txn_q;
        err_d     = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_write ? cmd_wdata : '0;
                    wstrb_d = cmd_write ? cmd_wstrb : '0;
                    state_d = cmd_write ? S_WR_REQ : S_RD_REQ;
                end
            end
            S_WR_REQ: begin
                // VALID is high exactly while the done flag is clear, so
                // READY alone marks the handshake.
                aw_done_d = aw_done_q | M_AXI_AWREADY;
                w_done_d  = w_done_q | M_AXI_WREADY;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (M_AXI_BVALID) begin
                    resp_d  = M_AXI_BRESP;
                    rdata_d = '0;
                    state_d = S_RSP;
                end
            end
            S_RD_REQ: begin
                if (M_AXI_ARREADY) state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (M_AXI_RVALID) begin
                    rdata_d = M_AXI_RDATA;
                    resp_d  = M_AXI_RRESP;
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    txn_d = txn_q + 32'd1;
                    if (resp_q != 2'b00) err_d = err_q + 32'd1;
                    // Clearing the latched command parks the bus outputs at 0.
                    addr_d  = '0;
                    wdata_d = '0;
                    wstrb_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready     = (state_q == S_IDLE) && S_AXI_ARESETN;
    assign busy          = (state_q != S_IDLE);
    assign rsp_valid     = (state_q == S_RSP);
    assign rsp_write     = write_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;
    assign M_AXI_AWADDR  = write_q ? addr_q : '0;
    assign M_AXI_ARADDR  = write_q ? '0 : addr_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_AWVALID = (state_q == S_WR_REQ) && !aw_done_q;
    assign M_AXI_WVALID  = (state_q == S_WR_REQ) && !w_done_q;
    assign M_AXI_BREADY  = (state_q == S_WR_RESP);
    assign M_AXI_ARVALID = (state_q == S_RD_REQ);
    assign M_AXI_RREADY  = (state_q == S_RD_DATA);
    assign txn_cntr      = txn_q;
    assign err_cntr      = err_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Self-checking bench for axi_lite_cmd_master: a scripted AXI4-Lite slave with
// random delays, checked against a transaction-level expectation model.
module tb_axi_lite_cmd_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [29:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [29:0] awaddr, araddr;
    logic        awvalid, awready, wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready;
    logic [31:0] rdata;
    logic        rvalid, rready, busy;
    logic [31:0] txn_cntr, err_cntr;

    always #5 clk = ~clk;

    axi_lite_cmd_master dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
        .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
        .M_AXI_RREADY(rready),
        .busy(busy), .txn_cntr(txn_cntr), .err_cntr(err_cntr)
    );

    int     checks = 0;
    int     errors = 0;
    int     exp_txn = 0;
    int     exp_err = 0;
    longint last_acc = -1;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic slave_idle();
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rresp = 0; rdata = 0;
        rsp_ready = 0;
    endtask

    // One command from acceptance to response handshake. Called on a negedge.
    // wr: d1 = AWREADY delay, d2 = WREADY delay, d3 = BVALID delay.
    // rd: d1 = ARREADY delay, d3 = RVALID delay after AR.
    task automatic do_txn(input bit wr, input logic [29:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          input int d1, input int d2, input int d3,
                          input logic [1:0] resp, input logic [31:0] rd,
                          input int hold);
        bit aw_ok, w_ok, ar_ok, dat_ok, fin, dv, rr;
        int pd, rc;
        logic [5:0] vr;
        longint acc;
        aw_ok = 0; w_ok = 0; ar_ok = 0; dat_ok = 0; fin = 0;
        pd = 0; rc = 0;
        check("idle", {cmd_ready, busy, rsp_valid}, 3'b100);
        check("idle_bus", {awaddr, wdata, wstrb, araddr}, '0);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a;
        cmd_wdata = d; cmd_wstrb = s;
        @(posedge clk);
        acc = longint'($time);
        if (last_acc >= 0) check("spacing", ((acc - last_acc) / 10) >= 4, 1);
        last_acc = acc;
        @(negedge clk);
        cmd_valid = 0; cmd_write = ~wr; cmd_addr = ~a;
        cmd_wdata = $urandom; cmd_wstrb = ~s;
        for (int k = 1; k < 300 && !fin; k++) begin
            vr = {awvalid, wvalid, bready, arvalid, rready, rsp_valid};
            check("valid_ready", vr,
                  {wr && !aw_ok, wr && !w_ok, wr && aw_ok && w_ok && !dat_ok,
                   !wr && !ar_ok, !wr && ar_ok && !dat_ok, dat_ok});
            check("busy", {busy, cmd_ready}, 2'b10);
            if (awvalid) check("awaddr", awaddr, a);
            if (wvalid) check("wdata", {wstrb, wdata}, {s, d});
            if (arvalid) check("araddr", araddr, a);
            if (rsp_valid)
                check("rsp", {rsp_write, rsp_resp, rsp_rdata},
                      {wr, resp, wr ? 32'h0 : rd});
            awready = (k > d1);
            wready  = (k > d2);
            arready = (k > d1);
            dv = 0;
            if (wr ? (aw_ok && w_ok) : ar_ok) begin
                dv = (pd >= d3) && !dat_ok;
                pd++;
            end
            bvalid = wr && dv;
            rvalid = !wr && dv;
            bresp = resp; rresp = resp;
            rdata = dv ? rd : $urandom;
            rr = dat_ok && (rc >= hold);
            if (dat_ok) rc++;
            rsp_ready = rr;
            @(posedge clk);
            if (vr[5] && awready) aw_ok = 1;
            if (vr[4] && wready) w_ok = 1;
            if (vr[3] && bvalid) dat_ok = 1;
            if (vr[2] && arready) ar_ok = 1;
            if (vr[1] && rvalid) dat_ok = 1;
            if (vr[0] && rr) begin
                fin = 1;
                exp_txn++;
                if (resp != 2'b00) exp_err++;
            end
            @(negedge clk);
        end
        if (!fin) check("timeout", 0, 1);
        slave_idle();
        check("txn_cntr", txn_cntr, 32'(exp_txn));
        check("err_cntr", err_cntr, 32'(exp_err));
    endtask

    initial begin
        logic [31:0] r32;
        logic [1:0]  rs;
        bit          rw;
        rst_n = 0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        slave_idle();
        #1;
        check("reset_outs",
              {cmd_ready, busy, awvalid, wvalid, bready, arvalid, rready,
               rsp_valid, rsp_write, rsp_resp, rsp_rdata}, '0);
        check("reset_cnt", {txn_cntr, err_cntr}, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        check("post_reset", {cmd_ready, busy}, 2'b10);
        @(negedge clk);

        do_txn(1, 30'h0, 32'h1, 4'hF, 0, 0, 0, 2'b00, 32'h0, 0);
        do_txn(1, 30'h40, 32'hCAFE_0001, 4'h3, 3, 0, 1, 2'b00, 32'h0, 0);
        do_txn(0, 30'h0100_0004, 32'h0, 4'h0, 2, 0, 5, 2'b00, 32'hDEAD_BEEF, 0);
        do_txn(1, 30'h88, 32'h1234_5678, 4'hF, 0, 0, 0, 2'b10, 32'h0, 0);
        do_txn(1, 30'h10, 32'hAAAA_5555, 4'hF, 0, 0, 0, 2'b00, 32'h0, 4);
        do_txn(0, 30'h14, 32'h0, 4'h0, 0, 0, 0, 2'b00, 32'h0BAD_F00D, 0);
        do_txn(1, 30'h18, 32'h5555_AAAA, 4'h8, 0, 0, 0, 2'b00, 32'h0, 0);

        for (int n = 0; n < 40; n++) begin
            r32 = $urandom;
            rw = 1'($urandom_range(0, 1));
            rs = 2'($urandom_range(0, 3));
            do_txn(rw, r32[29:0], $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 4), $urandom_range(0, 4),
                   $urandom_range(0, 4), rs, $urandom, $urandom_range(0, 3));
        end

        // Reset while a write is stuck in the request phase.
        check("pre_rst_idle", {cmd_ready, busy}, 2'b10);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 30'h2000;
        cmd_wdata = 32'h7777_7777; cmd_wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0;
        check("stall_awvalid", {awvalid, wvalid, busy}, 3'b111);
        #2;
        rst_n = 0;
        #1;
        check("rst_valids",
              {awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy,
               cmd_ready}, '0);
        check("rst_bus", {awaddr, wdata, wstrb, araddr}, '0);
        check("rst_cnt", {txn_cntr, err_cntr}, '0);
        exp_txn = 0; exp_err = 0; last_acc = -1;
        @(negedge clk);
        rst_n = 1;
        #1;
        check("rst_release", {cmd_ready, busy, awvalid}, 3'b100);
        @(negedge clk);
        do_txn(0, 30'h3000, 32'h0, 4'h0, 1, 0, 2, 2'b11, 32'h1357_9BDF, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
